// File: rtl/mem_stage_ctrl_pkg.sv
// Shared LC-3b MEM-stage types: word/mask typedefs, FSM state encoding and
// write-lane mask constants used by the controller and its byte aligner.
package mem_stage_ctrl_pkg;

  localparam int LC3B_WORD_W = 16;

  typedef logic [LC3B_WORD_W-1:0] lc3b_word;
  typedef logic [1:0]             lc3b_mem_wmask;

  typedef enum logic [1:0] {
    MS_IDLE   = 2'd0,
    MS_ACCESS = 2'd1,
    MS_HOLD   = 2'd2
  } mem_stage_state_t;

  localparam lc3b_mem_wmask WMASK_NONE = 2'b00;
  localparam lc3b_mem_wmask WMASK_LO   = 2'b01;
  localparam lc3b_mem_wmask WMASK_HI   = 2'b10;
  localparam lc3b_mem_wmask WMASK_WORD = 2'b11;

  function automatic lc3b_mem_wmask lane_mask(input logic lane);
    return lane ? WMASK_HI : WMASK_LO;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory port between the MEM-stage controller (master) and the data
// cache / memory (slave).
interface mem_stage_ctrl_if
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DATA_W = 16
) ();

  logic              dmem_read;
  logic              dmem_write;
  logic [DATA_W-1:0] dmem_address;
  logic [DATA_W-1:0] dmem_wdata;
  lc3b_mem_wmask     dmem_byte_enable;
  logic              dmem_resp;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  dmem_resp, dmem_rdata
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output dmem_resp, dmem_rdata
  );

endinterface

// File: rtl/mem_stage_ctrl_byte_align.sv
// Combinational byte-lane logic: write lane mask, store-data replication for
// byte stores and zero-extended lane selection for byte loads.
module mem_stage_ctrl_byte_align
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              lane_i,
  input  logic              byte_op_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output lc3b_mem_wmask     be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int HALF = DATA_W / 2;

  // NOTE: every output gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    be_o    = WMASK_WORD;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    if (byte_op_i) begin
      be_o    = lane_mask(lane_i);
      wdata_o = {2{wdata_i[HALF-1:0]}};
      rdata_o = {{HALF{1'b0}}, lane_i ? rdata_i[DATA_W-1:HALF] : rdata_i[HALF-1:0]};
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// LC-3b MEM-stage controller: issues one stable data-memory request per load or
// store, stalls the pipeline until the response, and hands aligned data to WB.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stage_valid,
  input  logic              flush,
  input  logic              ctrl_mem_read,
  input  logic              ctrl_mem_write,
  input  logic              ctrl_byte_op,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  mem_stage_ctrl_if.master  dmem,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] rdata_out,
  output logic              timeout_err
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam bit              WD_EN    = (TIMEOUT > 0);

  mem_stage_state_t  state_q;
  logic              read_q, write_q;
  logic [DATA_W-1:0] address_q, wdata_q, rdata_q;
  lc3b_mem_wmask     be_q;
  logic              done_q, timeout_err_q, squash_q;
  logic              lane_q, byte_op_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              memop, squash_d, wd_hit;
  logic              align_lane, align_byte_op;
  lc3b_mem_wmask     align_be;
  logic [DATA_W-1:0] align_wdata, align_rdata;

  assign memop    = stage_valid & (ctrl_mem_read | ctrl_mem_write) & ~flush;
  assign squash_d = squash_q | flush;
  assign wd_hit   = WD_EN && (state_q == MS_ACCESS) && (cnt_q == CNT_LAST) && !dmem.dmem_resp;

  // Live inputs drive the aligner while capturing a request; the captured lane
  // and width take over once the access is in flight.
  assign align_lane    = (state_q == MS_IDLE) ? addr[0]      : lane_q;
  assign align_byte_op = (state_q == MS_IDLE) ? ctrl_byte_op : byte_op_q;

  mem_stage_ctrl_byte_align #(.DATA_W(DATA_W)) u_byte_align (
    .lane_i    (align_lane),
    .byte_op_i (align_byte_op),
    .wdata_i   (wdata),
    .rdata_i   (dmem.dmem_rdata),
    .be_o      (align_be),
    .wdata_o   (align_wdata),
    .rdata_o   (align_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= MS_IDLE;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      address_q     <= '0;
      wdata_q       <= '0;
      be_q          <= WMASK_NONE;
      done_q        <= 1'b0;
      rdata_q       <= '0;
      timeout_err_q <= 1'b0;
      squash_q      <= 1'b0;
      lane_q        <= 1'b0;
      byte_op_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        MS_IDLE: begin
          done_q   <= 1'b0;
          squash_q <= 1'b0;
          cnt_q    <= '0;
          if (memop) begin
            write_q   <= ctrl_mem_write;
            read_q    <= ctrl_mem_read & ~ctrl_mem_write;
            address_q <= {addr[DATA_W-1:1], 1'b0};
            wdata_q   <= align_wdata;
            be_q      <= ctrl_mem_write ? align_be : WMASK_NONE;
            lane_q    <= addr[0];
            byte_op_q <= ctrl_byte_op;
            state_q   <= MS_ACCESS;
          end
        end

        MS_ACCESS: begin
          squash_q <= squash_d;
          if (dmem.dmem_resp) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            done_q  <= ~squash_d;
            if (!squash_d) rdata_q <= align_rdata;
            state_q <= MS_HOLD;
          end else if (wd_hit) begin
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            done_q        <= ~squash_d;
            rdata_q       <= '0;
            timeout_err_q <= 1'b1;
            state_q       <= MS_HOLD;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        MS_HOLD: begin
          done_q  <= 1'b0;
          state_q <= MS_IDLE;
        end

        default: state_q <= MS_IDLE;
      endcase
    end
  end

  assign stall = ((state_q == MS_IDLE) && memop) || (state_q == MS_ACCESS);

  assign dmem.dmem_read        = read_q;
  assign dmem.dmem_write       = write_q;
  assign dmem.dmem_address     = address_q;
  assign dmem.dmem_wdata       = wdata_q;
  assign dmem.dmem_byte_enable = be_q;

  assign done        = done_q;
  assign rdata_out   = rdata_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus randomized
// loads/stores against a transaction-level reference model.
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst_n, stage_valid, flush;
  logic              mem_rd, mem_wr, byte_op;
  logic [DATA_W-1:0] addr, wdata;
  logic              stall, done, timeout_err;
  logic [DATA_W-1:0] rdata_out;

  always #5 clk = ~clk;

  mem_stage_ctrl_if #(.DATA_W(DATA_W)) dmem_bus ();

  mem_stage_ctrl #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stage_valid    (stage_valid),
    .flush          (flush),
    .ctrl_mem_read  (mem_rd),
    .ctrl_mem_write (mem_wr),
    .ctrl_byte_op   (byte_op),
    .addr           (addr),
    .wdata          (wdata),
    .dmem           (dmem_bus),
    .stall          (stall),
    .done           (done),
    .rdata_out      (rdata_out),
    .timeout_err    (timeout_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference-model state: last delivered load data and sticky watchdog flag.
  logic [15:0] rdata_exp = '0;
  logic        te_exp    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] exp_addr(input logic [15:0] a);
    return a - (a % 2);
  endfunction

  function automatic logic [1:0] exp_be(input logic wr, input logic bt, input logic [15:0] a);
    if (!wr) return 2'd0;
    if (!bt) return 2'd3;
    return (a % 2 == 1) ? 2'd2 : 2'd1;
  endfunction

  function automatic logic [15:0] exp_wdata(input logic bt, input logic [15:0] w);
    return bt ? (w % 256) * 257 : w;
  endfunction

  function automatic logic [15:0] exp_rdata(input logic bt, input logic [15:0] a, input logic [15:0] r);
    if (!bt) return r;
    return (a % 2 == 1) ? r / 256 : r % 256;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle with no memory operation presented (bubble, flushed op, or non-mem op).
  task automatic idle_cycle(input logic v, input logic fl, input logic rd, input logic wr);
    tick();
    stage_valid = v; flush = fl; mem_rd = rd; mem_wr = wr; byte_op = 1'b0;
    addr = 16'($urandom); wdata = 16'($urandom);
    dmem_bus.dmem_resp = 1'b0; dmem_bus.dmem_rdata = 16'($urandom);
    @(negedge clk);
    check("idle_stall", stall, 0);
    check("idle_req", {dmem_bus.dmem_read, dmem_bus.dmem_write}, 0);
    check("idle_done", done, 0);
  endtask

  // One full MEM-stage occupancy: IDLE capture, ACCESS until resp/watchdog, HOLD.
  task automatic run_op(input logic rd, input logic wr, input logic bt,
                        input logic [15:0] a, input logic [15:0] wd, input logic [15:0] rd_data,
                        input int delay, input int flush_at);
    bit squash    = 1'b0;
    bit timed_out = (delay >= TIMEOUT);
    int last      = timed_out ? TIMEOUT - 1 : delay;

    tick();
    stage_valid = 1'b1; flush = 1'b0; mem_rd = rd; mem_wr = wr; byte_op = bt;
    addr = a; wdata = wd; dmem_bus.dmem_resp = 1'b0;
    @(negedge clk);
    check("cap_stall", stall, 1);
    check("cap_req", {dmem_bus.dmem_read, dmem_bus.dmem_write}, 0);

    for (int k = 0; k <= last; k++) begin
      tick();
      dmem_bus.dmem_resp  = (k == delay);
      dmem_bus.dmem_rdata = (k == delay) ? rd_data : 16'($urandom);
      flush = (k == flush_at);
      if (k == flush_at) squash = 1'b1;
      @(negedge clk);
      check("acc_read", dmem_bus.dmem_read, wr ? 0 : 1);
      check("acc_write", dmem_bus.dmem_write, wr);
      check("acc_addr", dmem_bus.dmem_address, exp_addr(a));
      check("acc_be", dmem_bus.dmem_byte_enable, exp_be(wr, bt, a));
      if (wr) check("acc_wdata", dmem_bus.dmem_wdata, exp_wdata(bt, wd));
      check("acc_stall", stall, 1);
      check("acc_done", done, 0);
    end

    tick();
    dmem_bus.dmem_resp = 1'b0; flush = 1'b0; dmem_bus.dmem_rdata = 16'($urandom);
    if (timed_out) begin
      te_exp    = 1'b1;
      rdata_exp = '0;
    end else if (!squash) begin
      rdata_exp = exp_rdata(bt, a, rd_data);
    end
    @(negedge clk);
    check("hold_done", done, squash ? 0 : 1);
    check("hold_stall", stall, 0);
    check("hold_req", {dmem_bus.dmem_read, dmem_bus.dmem_write}, 0);
    check("hold_rdata", rdata_out, rdata_exp);
    check("hold_timeout_err", timeout_err, te_exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_read"}, dmem_bus.dmem_read, 0);
    check({tag, "_write"}, dmem_bus.dmem_write, 0);
    check({tag, "_addr"}, dmem_bus.dmem_address, 0);
    check({tag, "_wdata"}, dmem_bus.dmem_wdata, 0);
    check({tag, "_be"}, dmem_bus.dmem_byte_enable, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rdata"}, rdata_out, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_stall"}, stall, 0);
  endtask

  initial begin
    rst_n = 1'b0; stage_valid = 1'b0; flush = 1'b0;
    mem_rd = 1'b0; mem_wr = 1'b0; byte_op = 1'b0;
    addr = '0; wdata = '0;
    dmem_bus.dmem_resp = 1'b0; dmem_bus.dmem_rdata = '0;

    tick(); tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;

    // Word store, response after two wait cycles.
    run_op(1'b0, 1'b1, 1'b0, 16'h3001, 16'hBEEF, 16'h0000, 2, -1);
    // Byte loads from both lanes.
    run_op(1'b1, 1'b0, 1'b1, 16'h4005, 16'h0000, 16'hA55A, 1, -1);
    check("ldb_hi_lane", rdata_out, 16'h00A5);
    run_op(1'b1, 1'b0, 1'b1, 16'h4004, 16'h0000, 16'hA55A, 0, -1);
    check("ldb_lo_lane", rdata_out, 16'h005A);
    // Byte store to the high lane.
    run_op(1'b0, 1'b1, 1'b1, 16'h2003, 16'h1234, 16'h0000, 1, -1);
    // Flushed word loads: early in ACCESS, and on the response cycle.
    run_op(1'b1, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'hCAFE, 2, 0);
    run_op(1'b1, 1'b0, 1'b0, 16'h1002, 16'h0000, 16'hF00D, 1, 1);
    // Flush while idle: no request, no stall.
    idle_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    idle_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    // Watchdog expiry, then sticky across a normal access.
    run_op(1'b1, 1'b0, 1'b0, 16'h5555, 16'h0000, 16'h0000, 100, -1);
    run_op(1'b1, 1'b0, 1'b0, 16'h5556, 16'h0000, 16'h7777, 3, -1);

    // Reset during ACCESS drops everything on the next edge.
    tick();
    stage_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; addr = 16'h6000;
    tick();
    stage_valid = 1'b0; mem_rd = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("pre_rst_read", dmem_bus.dmem_read, 1);
    tick();
    rst_n = 1'b1;
    te_exp = 1'b0; rdata_exp = '0;
    @(negedge clk);
    check_all_zero("mid_rst");

    // Back-to-back zero-wait accesses, including read+write (write wins).
    run_op(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h1111, 0, -1);
    run_op(1'b0, 1'b1, 1'b0, 16'h0102, 16'h2222, 16'h0000, 0, -1);
    run_op(1'b1, 1'b1, 1'b1, 16'h0105, 16'h3344, 16'h0000, 0, -1);
    run_op(1'b1, 1'b0, 1'b1, 16'h0107, 16'h0000, 16'h9876, 0, -1);

    for (int i = 0; i < 300; i++) begin
      int sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        idle_cycle(1'($urandom), 1'($urandom), 1'b0, 1'b0);
      end else begin
        logic rd  = 1'($urandom);
        logic wr  = rd ? 1'($urandom) : 1'b1;
        int   dly = ($urandom_range(0, 15) == 0) ? 6 : int'($urandom_range(0, 3));
        int   fa  = (dly < TIMEOUT && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, dly)) : -1;
        run_op(rd, wr, 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), dly, fa);
      end
    end
    idle_cycle(1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
